// File: rtl/fp_mac_if.sv
// Operand, result and control bundle for the fixed-point MAC stage.
interface fp_mac_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/fp_mac.sv
// Sequential signed Q-format multiply-accumulate with guarded
// accumulator and saturated N-bit dot-product result.
module fp_mac #(
  parameter int N     = 8,
  parameter int F     = 7,
  parameter int G     = 4,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  fp_mac_if.slave  bus
);
  localparam int PW    = 2*N - F;
  localparam int ACC_W = PW + G;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((1 << (N-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(1 << (N-1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic [N-1:0]            result_q;
  logic                    overflow_q;

  logic signed [2*N-1:0]   prod;
  logic signed [PW-1:0]    p;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [N-1:0]            sat_val;
  logic                    sat_ovf;
  logic                    hs;
  logic                    last;

  // Truncating the low F bits of the full product is an arithmetic
  // shift right: it floors toward minus infinity.
  assign prod    = $signed(bus.a) * $signed(bus.b);
  assign p       = prod[2*N-1:F];
  assign p_ext   = {{G{p[PW-1]}}, p};
  assign acc_sum = acc + p_ext;

  assign hs   = bus.in_valid && bus.in_ready;
  assign last = hs && (count == CNT_W'(1));

  always_comb begin
    sat_val = acc_sum[N-1:0];
    sat_ovf = 1'b0;
    if (acc_sum > SAT_MAX) begin
      sat_val = SAT_MAX[N-1:0];
      sat_ovf = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      sat_val = SAT_MIN[N-1:0];
      sat_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) state_nx = ACCUM;
          else               state_nx = DONE;
        end
      end
      ACCUM: if (last)          state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            count <= bus.len;
            if (bus.len == '0) begin
              result_q   <= '0;
              overflow_q <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (hs) begin
            acc   <= acc_sum;
            count <= count - CNT_W'(1);
          end
          if (last) begin
            result_q   <= sat_val;
            overflow_q <= sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fp_mac.sv
// Directed bench for fp_mac: hand-computed Q1.7 dot products,
// saturation, zero length, reset abort and handshake corner cases.
module tb_fp_mac;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fp_mac_if #(.N(8), .CNT_W(8)) bus ();

  fp_mac #(.N(8), .F(7), .G(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  logic [7:0] va [4];
  logic [7:0] vb [4];

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_oval",   32'(bus.out_valid), 32'd0);
    chk("rst_irdy",   32'(bus.in_ready),  32'd0);
    chk("rst_result", 32'(bus.result),    32'h00);
    chk("rst_ovf",    32'(bus.overflow),  32'd0);

    // 0.5*0.5 twice = 0.5
    bus.start = 1'b1; bus.len = 8'd2;
    tick();
    bus.start = 1'b0;
    chk("t1_irdy", 32'(bus.in_ready), 32'd1);
    chk("t1_busy", 32'(bus.busy),     32'd1);
    bus.in_valid = 1'b1; bus.a = 8'h40; bus.b = 8'h40;
    tick();
    chk("t1_early", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_oval",   32'(bus.out_valid), 32'd1);
    chk("t1_irdy_0", 32'(bus.in_ready),  32'd0);
    chk("t1_result", 32'(bus.result),    32'h40);
    chk("t1_ovf",    32'(bus.overflow),  32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_idle", 32'(bus.busy),   32'd0);
    chk("t1_hold", 32'(bus.result), 32'h40);

    // reset mid-ACCUM
    bus.start = 1'b1; bus.len = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h40; bus.b = 8'h40;
    tick();
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("mr_busy",   32'(bus.busy),      32'd0);
    chk("mr_oval",   32'(bus.out_valid), 32'd0);
    chk("mr_irdy",   32'(bus.in_ready),  32'd0);
    chk("mr_result", 32'(bus.result),    32'h00);
    tick(); tick(); tick();
    chk("mr_noemit", 32'(bus.out_valid), 32'd0);

    // in_valid with start in IDLE: pair must not be consumed
    bus.start = 1'b1; bus.len = 8'd1;
    bus.in_valid = 1'b1; bus.a = 8'h7F; bus.b = 8'h7F;
    tick();
    bus.start = 1'b0;
    bus.a = 8'h40; bus.b = 8'h40;
    tick();
    bus.in_valid = 1'b0;
    chk("iv_oval",   32'(bus.out_valid), 32'd1);
    chk("iv_result", 32'(bus.result),    32'h20);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // -1 * -1 saturates positive
    bus.start = 1'b1; bus.len = 8'd1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h80; bus.b = 8'h80;
    tick();
    bus.in_valid = 1'b0;
    chk("t2_oval",   32'(bus.out_valid), 32'd1);
    chk("t2_result", 32'(bus.result),    32'h7F);
    chk("t2_ovf",    32'(bus.overflow),  32'd1);

    // start together with out_ready in DONE is dropped
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.len = 8'd3;
    tick();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("sd_busy", 32'(bus.busy),     32'd0);
    chk("sd_irdy", 32'(bus.in_ready), 32'd0);

    // 3 x (-1 * 127/128) = -381/128 -> clamp low
    bus.start = 1'b1; bus.len = 8'd3;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h80; bus.b = 8'h7F;
    tick(); tick(); tick();
    bus.in_valid = 1'b0;
    chk("t3_oval",   32'(bus.out_valid), 32'd1);
    chk("t3_result", 32'(bus.result),    32'h80);
    chk("t3_ovf",    32'(bus.overflow),  32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // zero length goes straight to DONE
    bus.start = 1'b1; bus.len = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("z_oval",   32'(bus.out_valid), 32'd1);
    chk("z_result", 32'(bus.result),    32'h00);
    chk("z_ovf",    32'(bus.overflow),  32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("z_stall_oval", 32'(bus.out_valid), 32'd1);
      chk("z_stall_res",  32'(bus.result),    32'h00);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("z_release", 32'(bus.out_valid), 32'd0);

    // len=4, in_valid 1010..., junk on idle cycles, stray start
    // products: 16 + 15 + (-8) + (-1) = 22
    va[0] = 8'h20; vb[0] = 8'h40;
    va[1] = 8'h10; vb[1] = 8'h7F;
    va[2] = 8'hF0; vb[2] = 8'h40;
    va[3] = 8'hFF; vb[3] = 8'h01;
    bus.start = 1'b1; bus.len = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = (i % 2 == 0) ? va[i/2] : 8'h7F;
      bus.b = (i % 2 == 0) ? vb[i/2] : 8'h7F;
      bus.start = (i == 3);
      bus.len   = (i == 3) ? 8'd1 : 8'd0;
      tick();
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
    chk("t4_oval",   32'(bus.out_valid), 32'd1);
    chk("t4_result", 32'(bus.result),    32'h16);
    chk("t4_ovf",    32'(bus.overflow),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_wait_oval", 32'(bus.out_valid), 32'd1);
      chk("t4_wait_res",  32'(bus.result),    32'h16);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t4_done", 32'(bus.out_valid), 32'd0);
    chk("t4_idle", 32'(bus.busy),      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
